// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multicycle MIPS main control FSM
// and its control-word decoder.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BEQ    = 4'd8,
    BNE    = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11,
    JUMP   = 4'd12,
    TRAP   = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_OUT  = 2'b01;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;

  typedef struct packed {
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       memtoreg;
    logic       regwrite;
    logic       regdst;
    logic       alusrca;
    logic       branch;
    logic       branchne;
    logic       pcwrite;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       illegal;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  // States whose exit back to FETCH retires an instruction.
  function automatic logic is_terminal(state_t s);
    case (s)
      MEMWB, MEMWR, ALUWB, BEQ, BNE, ADDIWB, JUMP: is_terminal = 1'b1;
      default:                                     is_terminal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational state-to-control-word decoder; shared by the main FSM
// and the trace monitor so both agree on what each state drives.
module mc_ctrl_outdec
  import mips_mc_pkg::*;
#(
  parameter bit ENABLE_BNE = 1'b1
) (
  input  logic [3:0]        state,
  output logic [CTRL_W-1:0] ctrl
);

  ctrl_t c;

  always_comb begin
    c = '0;
    case (state_t'(state))
      FETCH: begin
        c.alusrcb = SRCB_FOUR;
        c.irwrite = 1'b1;
        c.pcwrite = 1'b1;
        c.aluop   = ALU_ADD;
        c.pcsrc   = PCSRC_ALU;
      end
      DECODE: c.alusrcb = SRCB_IMMSH;
      MEMADR, ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
      end
      MEMRD: c.iord = 1'b1;
      MEMWB: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
      end
      MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      EXEC: begin
        c.alusrca = 1'b1;
        c.aluop   = ALU_FUNCT;
      end
      ALUWB: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b1;
      end
      BEQ: begin
        c.alusrca = 1'b1;
        c.aluop   = ALU_SUB;
        c.pcsrc   = PCSRC_OUT;
        c.branch  = 1'b1;
      end
      BNE: begin
        c.alusrca  = 1'b1;
        c.aluop    = ALU_SUB;
        c.pcsrc    = PCSRC_OUT;
        c.branchne = ENABLE_BNE;
      end
      ADDIWB: c.regwrite = 1'b1;
      JUMP: begin
        c.pcsrc   = PCSRC_JUMP;
        c.pcwrite = 1'b1;
      end
      TRAP: c.illegal = 1'b1;
      default: ;
    endcase
  end

  assign ctrl = c;

endmodule

// File: rtl/mc_main_fsm.sv
// Multicycle MIPS main control FSM: state register, next-state logic,
// registered Moore control word and retired-instruction counter.
//
// state  | meaning
// FETCH  | read instruction, PC += 4 (holds for mem_ready when handshaking)
// DECODE | register read, branch target into ALUOut
// MEMADR | LW/SW effective address
// MEMRD  | LW data read (holds for mem_ready when handshaking)
// MEMWB  | LW register writeback
// MEMWR  | SW data write (holds for mem_ready when handshaking)
// EXEC   | R-type ALU operation
// ALUWB  | R-type register writeback
// BEQ    | compare, branch if equal
// BNE    | compare, branch if not equal
// ADDIEX | ADDI ALU operation
// ADDIWB | ADDI register writeback
// JUMP   | PC <= jump target
// TRAP   | illegal opcode seen; sticky until reset
module mc_main_fsm
  import mips_mc_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 0,
  parameter int ENABLE_BNE    = 1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic             mem_ready,
  output logic             IorD,
  output logic             IRwrite,
  output logic             memwrite,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             regdst,
  output logic             alusrcA,
  output logic             branch,
  output logic             branchne,
  output logic             pcwrite,
  output logic [1:0]       alusrcB,
  output logic [1:0]       aluop,
  output logic [1:0]       pcsrc,
  output logic             illegal,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] retired
);

  state_t              state;
  state_t              state_nxt;
  state_t              dec_state;
  logic [CTRL_W-1:0]   ctrl_nxt;
  ctrl_t               ctrl_q;
  logic                mem_done;
  logic                fetch_ok;

  assign mem_done = (MEM_HANDSHAKE == 0) || mem_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:  if (mem_done) state_nxt = DECODE;
      DECODE: begin
        case (op)
          OP_RTYPE:     state_nxt = EXEC;
          OP_LW, OP_SW: state_nxt = MEMADR;
          OP_BEQ:       state_nxt = BEQ;
          OP_BNE:       state_nxt = (ENABLE_BNE != 0) ? BNE : TRAP;
          OP_ADDI:      state_nxt = ADDIEX;
          OP_J:         state_nxt = JUMP;
          default:      state_nxt = TRAP;
        endcase
      end
      MEMADR: state_nxt = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  if (mem_done) state_nxt = MEMWB;
      MEMWR:  if (mem_done) state_nxt = FETCH;
      EXEC:   state_nxt = ALUWB;
      ADDIEX: state_nxt = ADDIWB;
      MEMWB, ALUWB, BEQ, BNE, ADDIWB, JUMP: state_nxt = FETCH;
      TRAP:   state_nxt = TRAP;
      default: state_nxt = FETCH;
    endcase
  end

  // Decode the state being entered so the control word is registered
  // alongside the state and is valid from the first cycle of each state.
  assign dec_state = reset ? FETCH : state_nxt;

  mc_ctrl_outdec #(
    .ENABLE_BNE (ENABLE_BNE != 0)
  ) u_outdec (
    .state (dec_state),
    .ctrl  (ctrl_nxt)
  );

  always_ff @(posedge clk) begin
    ctrl_q <= ctrl_t'(ctrl_nxt);
    if (reset) begin
      state   <= FETCH;
      retired <= '0;
    end else begin
      state <= state_nxt;
      if (is_terminal(state) && (state_nxt == FETCH))
        retired <= retired + CNT_W'(1);
    end
  end

  // A stalled fetch must not latch the IR or bump the PC; JUMP's pcwrite
  // is never gated.
  assign fetch_ok = (state != FETCH) || mem_done;

  assign IorD     = ctrl_q.iord;
  assign IRwrite  = ctrl_q.irwrite & fetch_ok;
  assign memwrite = ctrl_q.memwrite;
  assign memtoreg = ctrl_q.memtoreg;
  assign regwrite = ctrl_q.regwrite;
  assign regdst   = ctrl_q.regdst;
  assign alusrcA  = ctrl_q.alusrca;
  assign branch   = ctrl_q.branch;
  assign branchne = ctrl_q.branchne;
  assign pcwrite  = ctrl_q.pcwrite & fetch_ok;
  assign alusrcB  = ctrl_q.alusrcb;
  assign aluop    = ctrl_q.aluop;
  assign pcsrc    = ctrl_q.pcsrc;
  assign illegal  = ctrl_q.illegal;
  assign state_o  = state;

endmodule

// File: tb/tb_mc_main_fsm.sv
// Bench for mc_main_fsm: per-cycle expected trace queued with the stimulus,
// popped and compared against two differently parameterised instances.
module tb_mc_main_fsm;
  import mips_mc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // d0: MEM_HANDSHAKE=0, ENABLE_BNE=1, CNT_W=32
  logic        rst0, mr0;
  logic [5:0]  op0;
  logic        iord0, irw0, mw0, mtr0, rw0, rd0, asa0, br0, bne0, pcw0, ill0;
  logic [1:0]  asb0, aop0, psrc0;
  logic [3:0]  st0;
  logic [31:0] ret0;

  // d1: MEM_HANDSHAKE=1, ENABLE_BNE=0, CNT_W=2
  logic        rst1, mr1;
  logic [5:0]  op1;
  logic        iord1, irw1, mw1, mtr1, rw1, rd1, asa1, br1, bne1, pcw1, ill1;
  logic [1:0]  asb1, aop1, psrc1;
  logic [3:0]  st1;
  logic [1:0]  ret1;

  mc_main_fsm #(.MEM_HANDSHAKE(0), .ENABLE_BNE(1), .CNT_W(32)) u_dut0 (
    .clk(clk), .reset(rst0), .op(op0), .mem_ready(mr0),
    .IorD(iord0), .IRwrite(irw0), .memwrite(mw0), .memtoreg(mtr0),
    .regwrite(rw0), .regdst(rd0), .alusrcA(asa0), .branch(br0),
    .branchne(bne0), .pcwrite(pcw0), .alusrcB(asb0), .aluop(aop0),
    .pcsrc(psrc0), .illegal(ill0), .state_o(st0), .retired(ret0)
  );

  mc_main_fsm #(.MEM_HANDSHAKE(1), .ENABLE_BNE(0), .CNT_W(2)) u_dut1 (
    .clk(clk), .reset(rst1), .op(op1), .mem_ready(mr1),
    .IorD(iord1), .IRwrite(irw1), .memwrite(mw1), .memtoreg(mtr1),
    .regwrite(rw1), .regdst(rd1), .alusrcA(asa1), .branch(br1),
    .branchne(bne1), .pcwrite(pcw1), .alusrcB(asb1), .aluop(aop1),
    .pcsrc(psrc1), .illegal(ill1), .state_o(st1), .retired(ret1)
  );

  typedef struct {
    bit          d;
    bit          chk;
    logic        rst;
    logic [5:0]  op;
    logic        mr;
    state_t      st;
    logic [16:0] ctl;
    logic [31:0] ret;
    string       tag;
  } sb_t;

  sb_t         sb_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_ret [0:1];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // {IorD,IRwrite,memwrite,memtoreg,regwrite,regdst,alusrcA,branch,branchne,
  //  pcwrite,alusrcB[2],aluop[2],pcsrc[2],illegal}
  function automatic logic [16:0] exp_ctl(state_t s, logic gate);
    logic [16:0] v;
    case (s)
      FETCH:          v = gate ? 17'b0_0_0_0_0_0_0_0_0_0_01_00_00_0
                               : 17'b0_1_0_0_0_0_0_0_0_1_01_00_00_0;
      DECODE:         v = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
      MEMADR, ADDIEX: v = 17'b0_0_0_0_0_0_1_0_0_0_10_00_00_0;
      MEMRD:          v = 17'b1_0_0_0_0_0_0_0_0_0_00_00_00_0;
      MEMWB:          v = 17'b0_0_0_1_1_0_0_0_0_0_00_00_00_0;
      MEMWR:          v = 17'b1_0_1_0_0_0_0_0_0_0_00_00_00_0;
      EXEC:           v = 17'b0_0_0_0_0_0_1_0_0_0_00_10_00_0;
      ALUWB:          v = 17'b0_0_0_0_1_1_0_0_0_0_00_00_00_0;
      BEQ:            v = 17'b0_0_0_0_0_0_1_1_0_0_00_01_01_0;
      BNE:            v = 17'b0_0_0_0_0_0_1_0_1_0_00_01_01_0;
      ADDIWB:         v = 17'b0_0_0_0_1_0_0_0_0_0_00_00_00_0;
      JUMP:           v = 17'b0_0_0_0_0_0_0_0_0_1_00_00_10_0;
      TRAP:           v = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_1;
      default:        v = 17'b0;
    endcase
    return v;
  endfunction

  function automatic logic rnd();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic push(input bit d, input bit chk, input logic rst, input logic [5:0] op,
                      input logic mr, input state_t st, input logic gate, input string tag);
    sb_t e;
    e.d = d; e.chk = chk; e.rst = rst; e.op = op; e.mr = mr; e.st = st;
    e.ctl = exp_ctl(st, gate);
    e.ret = exp_ret[d];
    e.tag = $sformatf("d%0d %s %s", d, tag, st.name());
    sb_q.push_back(e);
  endtask

  task automatic push_reset(input bit d);
    logic mr;
    push(d, 1'b0, 1'b1, 6'd0, 1'b1, FETCH, 1'b0, "rst");
    exp_ret[d] = 32'd0;
    mr = rnd();
    push(d, 1'b1, 1'b1, 6'd0, mr, FETCH, d && !mr, "rst");
  endtask

  task automatic bump(input bit d);
    exp_ret[d] = d ? ((exp_ret[d] + 32'd1) & 32'd3) : (exp_ret[d] + 32'd1);
  endtask

  // fw/mw: low mem_ready cycles in FETCH and in MEMRD/MEMWR (d1 only)
  task automatic push_instr(input bit d, input logic [5:0] op, input int fw, input int mw,
                            input string nm);
    for (int i = 0; i < fw; i++) push(d, 1'b1, 1'b0, op, 1'b0, FETCH, 1'b1, nm);
    push(d, 1'b1, 1'b0, op, d ? 1'b1 : rnd(), FETCH, 1'b0, nm);
    push(d, 1'b1, 1'b0, op, rnd(), DECODE, 1'b0, nm);
    case (op)
      OP_LW: begin
        push(d, 1'b1, 1'b0, op, rnd(), MEMADR, 1'b0, nm);
        for (int i = 0; i < mw; i++) push(d, 1'b1, 1'b0, op, 1'b0, MEMRD, 1'b0, nm);
        push(d, 1'b1, 1'b0, op, d ? 1'b1 : rnd(), MEMRD, 1'b0, nm);
        push(d, 1'b1, 1'b0, op, rnd(), MEMWB, 1'b0, nm);
      end
      OP_SW: begin
        push(d, 1'b1, 1'b0, op, rnd(), MEMADR, 1'b0, nm);
        for (int i = 0; i < mw; i++) push(d, 1'b1, 1'b0, op, 1'b0, MEMWR, 1'b0, nm);
        push(d, 1'b1, 1'b0, op, d ? 1'b1 : rnd(), MEMWR, 1'b0, nm);
      end
      OP_RTYPE: begin
        push(d, 1'b1, 1'b0, op, rnd(), EXEC, 1'b0, nm);
        push(d, 1'b1, 1'b0, op, rnd(), ALUWB, 1'b0, nm);
      end
      OP_ADDI: begin
        push(d, 1'b1, 1'b0, op, rnd(), ADDIEX, 1'b0, nm);
        push(d, 1'b1, 1'b0, op, rnd(), ADDIWB, 1'b0, nm);
      end
      OP_BEQ: push(d, 1'b1, 1'b0, op, rnd(), BEQ, 1'b0, nm);
      OP_BNE: push(d, 1'b1, 1'b0, op, rnd(), BNE, 1'b0, nm);
      default: push(d, 1'b1, 1'b0, op, rnd(), JUMP, 1'b0, nm);
    endcase
    bump(d);
  endtask

  task automatic push_trap(input bit d, input logic [5:0] op, input int n);
    push(d, 1'b1, 1'b0, op, 1'b1, FETCH, 1'b0, "trap");
    push(d, 1'b1, 1'b0, op, rnd(), DECODE, 1'b0, "trap");
    for (int i = 0; i < n; i++) push(d, 1'b1, 1'b0, op, rnd(), TRAP, 1'b0, "trap");
  endtask

  task automatic push_idle_fetch(input bit d);
    push(d, 1'b1, 1'b0, 6'd0, 1'b0, FETCH, d, "tail");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    sb_t e;
    logic [16:0] ctl_obs;
    logic [3:0]  st_obs;
    logic [31:0] ret_obs;
    exp_ret[0] = 32'd0;
    exp_ret[1] = 32'd0;

    // d0: full instruction set, no stalls
    push_reset(1'b0);
    push_instr(1'b0, OP_LW,    0, 0, "lw");
    push_instr(1'b0, OP_SW,    0, 0, "sw");
    push_instr(1'b0, OP_BNE,   0, 0, "bne");
    push_instr(1'b0, OP_RTYPE, 0, 0, "rtype");
    push_instr(1'b0, OP_ADDI,  0, 0, "addi");
    push_instr(1'b0, OP_J,     0, 0, "j");
    push_instr(1'b0, OP_BEQ,   0, 0, "beq");
    // reset hits while in MEMRD; the following LW must start clean
    push(1'b0, 1'b1, 1'b0, OP_LW, 1'b1, FETCH,  1'b0, "rstmid");
    push(1'b0, 1'b1, 1'b0, OP_LW, 1'b1, DECODE, 1'b0, "rstmid");
    push(1'b0, 1'b1, 1'b0, OP_LW, 1'b1, MEMADR, 1'b0, "rstmid");
    push(1'b0, 1'b0, 1'b1, OP_LW, 1'b1, MEMRD,  1'b0, "rstmid");
    exp_ret[0] = 32'd0;
    push_instr(1'b0, OP_LW, 0, 0, "lw_after_rst");
    push_idle_fetch(1'b0);
    push_reset(1'b0);
    push_trap(1'b0, 6'b111111, 5);

    // d1: handshake stalls, BNE disabled, 2-bit counter
    push_reset(1'b1);
    push_instr(1'b1, OP_SW, 0, 3, "sw_wait");
    push_instr(1'b1, OP_LW, 2, 1, "lw_wait");
    push_idle_fetch(1'b1);
    push_reset(1'b1);
    push_instr(1'b1, OP_RTYPE, 0, 0, "rtype");
    push_instr(1'b1, OP_ADDI,  0, 0, "addi");
    push_instr(1'b1, OP_J,     0, 0, "j");
    push_instr(1'b1, OP_BEQ,   0, 0, "beq");
    push_idle_fetch(1'b1);
    push_reset(1'b1);
    push_instr(1'b1, OP_J, 0, 0, "j");
    push_trap(1'b1, OP_BNE, 20);

    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.d == 1'b0) begin
        rst0 = e.rst; op0 = e.op; mr0 = e.mr;
        rst1 = 1'b1;  op1 = 6'd0; mr1 = 1'b1;
      end else begin
        rst1 = e.rst; op1 = e.op; mr1 = e.mr;
        rst0 = 1'b1;  op0 = 6'd0; mr0 = 1'b1;
      end
      @(negedge clk);
      if (e.chk) begin
        if (e.d == 1'b0) begin
          st_obs  = st0;
          ctl_obs = {iord0, irw0, mw0, mtr0, rw0, rd0, asa0, br0, bne0, pcw0,
                     asb0, aop0, psrc0, ill0};
          ret_obs = ret0;
        end else begin
          st_obs  = st1;
          ctl_obs = {iord1, irw1, mw1, mtr1, rw1, rd1, asa1, br1, bne1, pcw1,
                     asb1, aop1, psrc1, ill1};
          ret_obs = {30'd0, ret1};
        end
        check_eq({e.tag, " state"},   {28'd0, st_obs},  {28'd0, e.st});
        check_eq({e.tag, " ctrl"},    {15'd0, ctl_obs}, {15'd0, e.ctl});
        check_eq({e.tag, " retired"}, ret_obs,          e.ret);
      end
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
